cache_bus_arbiter: RTL and testbench

Two-master arbiter sharing a single memory-side cache bus between the ICache refill port (read-only) and the DCache port (refill read plus dirty-line write-back). It sits between both caches and the memory/AXI bridge. It serialises whole burst transactions, alternates round-robin between the two caches on reads, and makes a DCache write-back and its following refill one atomic sequence. It also checks the beat count of every read burst.

---
 rtl/cache_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cache_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bus_arbiter.sv
// Two-master burst arbiter: ICache refill and DCache refill/write-back share one memory bus.
// Write-back and its following refill form one atomic sequence; read bursts are length-checked.
module cache_bus_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BEATS  = 2
) (
    input  logic              clock,
    input  logic              reset,
    // ICache read channel
    input  logic              i_r_valid,
    input  logic [ADDR_W-1:0] i_r_raddr,
    output logic [DATA_W-1:0] i_r_rdata,
    output logic              i_r_rlast,
    output logic              i_r_ready,
    // DCache read channel
    input  logic              d_r_valid,
    input  logic [ADDR_W-1:0] d_r_raddr,
    output logic [DATA_W-1:0] d_r_rdata,
    output logic              d_r_rlast,
    output logic              d_r_ready,
    // DCache write-back channel
    input  logic              d_w_valid,
    input  logic [ADDR_W-1:0] d_w_waddr,
    input  logic [DATA_W-1:0] d_w_wdata,
    input  logic              d_w_wlast,
    output logic              d_w_ready,
    input  logic              d_b_ready,
    output logic              d_b_valid,
    // Memory side
    output logic              mem_r_valid,
    output logic [ADDR_W-1:0] mem_r_raddr,
    input  logic [DATA_W-1:0] mem_r_rdata,
    input  logic              mem_r_rlast,
    input  logic              mem_r_ready,
    output logic              mem_w_valid,
    output logic [ADDR_W-1:0] mem_w_waddr,
    output logic [DATA_W-1:0] mem_w_wdata,
    output logic              mem_w_wlast,
    input  logic              mem_w_ready,
    input  logic              mem_b_valid,
    output logic              mem_b_ready,
    // Status
    output logic [1:0]        grant,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_IREAD  = 2'b01,
        ST_DREAD  = 2'b10,
        ST_DWRITE = 2'b11
    } state_t;

    localparam logic [2:0] BEATS_L = 3'(BEATS);

    state_t     state;
    logic       last_d;
    logic [1:0] beat_cnt;
    logic       r_fire_c;
    logic       b_fire_c;
    logic [2:0] beat_nxt_c;

    assign r_fire_c   = mem_r_valid & mem_r_ready;
    assign b_fire_c   = mem_b_valid & mem_b_ready;
    assign beat_nxt_c = {1'b0, beat_cnt} + 3'd1;
    assign grant      = 2'(state);

    // Arbitration state, round-robin history, beat counter and sticky burst error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            last_d    <= 1'b1;
            beat_cnt  <= 2'd0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (d_w_valid) begin
                        state  <= ST_DWRITE;
                        last_d <= 1'b1;
                    end else if (i_r_valid && (!d_r_valid || last_d)) begin
                        state    <= ST_IREAD;
                        last_d   <= 1'b0;
                        beat_cnt <= 2'd0;
                    end else if (d_r_valid) begin
                        state    <= ST_DREAD;
                        last_d   <= 1'b1;
                        beat_cnt <= 2'd0;
                    end
                end
                ST_IREAD, ST_DREAD: begin
                    if (r_fire_c) begin
                        beat_cnt <= (beat_cnt == 2'd3) ? 2'd3 : beat_cnt + 2'd1;
                        if ((mem_r_rlast && (beat_nxt_c != BEATS_L)) ||
                            (!mem_r_rlast && (beat_nxt_c >= BEATS_L)))
                            proto_err <= 1'b1;
                        if (mem_r_rlast)
                            state <= ST_IDLE;
                    end
                end
                ST_DWRITE: begin
                    // The refill follows the write-back directly so the ICache cannot slip in
                    if (b_fire_c) begin
                        if (d_r_valid) begin
                            state    <= ST_DREAD;
                            last_d   <= 1'b1;
                            beat_cnt <= 2'd0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Combinational routing between the granted master and memory
    always_comb begin
        i_r_rdata   = '0;
        i_r_rlast   = 1'b0;
        i_r_ready   = 1'b0;
        d_r_rdata   = '0;
        d_r_rlast   = 1'b0;
        d_r_ready   = 1'b0;
        d_w_ready   = 1'b0;
        d_b_valid   = 1'b0;
        mem_r_valid = 1'b0;
        mem_r_raddr = '0;
        mem_w_valid = 1'b0;
        mem_w_waddr = '0;
        mem_w_wdata = '0;
        mem_w_wlast = 1'b0;
        mem_b_ready = 1'b0;
        case (state)
            ST_IREAD: begin
                mem_r_valid = i_r_valid;
                mem_r_raddr = i_r_raddr;
                i_r_rdata   = mem_r_rdata;
                i_r_rlast   = mem_r_rlast;
                i_r_ready   = mem_r_ready;
            end
            ST_DREAD: begin
                mem_r_valid = d_r_valid;
                mem_r_raddr = d_r_raddr;
                d_r_rdata   = mem_r_rdata;
                d_r_rlast   = mem_r_rlast;
                d_r_ready   = mem_r_ready;
            end
            ST_DWRITE: begin
                mem_w_valid = d_w_valid;
                mem_w_waddr = d_w_waddr;
                mem_w_wdata = d_w_wdata;
                mem_w_wlast = d_w_wlast;
                d_w_ready   = mem_w_ready;
                mem_b_ready = d_b_ready;
                d_b_valid   = mem_b_valid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: read bursts, round-robin, write-back+refill,
// backpressure, burst-length errors and asynchronous reset, checked through a beat scoreboard.
module tb_cache_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        i_r_valid;
    logic [63:0] i_r_raddr;
    logic [63:0] i_r_rdata;
    logic        i_r_rlast;
    logic        i_r_ready;
    logic        d_r_valid;
    logic [63:0] d_r_raddr;
    logic [63:0] d_r_rdata;
    logic        d_r_rlast;
    logic        d_r_ready;
    logic        d_w_valid;
    logic [63:0] d_w_waddr;
    logic [63:0] d_w_wdata;
    logic        d_w_wlast;
    logic        d_w_ready;
    logic        d_b_ready;
    logic        d_b_valid;
    logic        mem_r_valid;
    logic [63:0] mem_r_raddr;
    logic [63:0] mem_r_rdata;
    logic        mem_r_rlast;
    logic        mem_r_ready;
    logic        mem_w_valid;
    logic [63:0] mem_w_waddr;
    logic [63:0] mem_w_wdata;
    logic        mem_w_wlast;
    logic        mem_w_ready;
    logic        mem_b_valid;
    logic        mem_b_ready;
    logic [1:0]  grant;
    logic        proto_err;

    int          n_tests;
    int          n_fail;
    int          wr_fires;
    logic [63:0] exp_q[$];

    cache_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .BEATS(2)) dut (
        .clock(clock), .reset(reset),
        .i_r_valid(i_r_valid), .i_r_raddr(i_r_raddr), .i_r_rdata(i_r_rdata),
        .i_r_rlast(i_r_rlast), .i_r_ready(i_r_ready),
        .d_r_valid(d_r_valid), .d_r_raddr(d_r_raddr), .d_r_rdata(d_r_rdata),
        .d_r_rlast(d_r_rlast), .d_r_ready(d_r_ready),
        .d_w_valid(d_w_valid), .d_w_waddr(d_w_waddr), .d_w_wdata(d_w_wdata),
        .d_w_wlast(d_w_wlast), .d_w_ready(d_w_ready),
        .d_b_ready(d_b_ready), .d_b_valid(d_b_valid),
        .mem_r_valid(mem_r_valid), .mem_r_raddr(mem_r_raddr), .mem_r_rdata(mem_r_rdata),
        .mem_r_rlast(mem_r_rlast), .mem_r_ready(mem_r_ready),
        .mem_w_valid(mem_w_valid), .mem_w_waddr(mem_w_waddr), .mem_w_wdata(mem_w_wdata),
        .mem_w_wlast(mem_w_wlast), .mem_w_ready(mem_w_ready),
        .mem_b_valid(mem_b_valid), .mem_b_ready(mem_b_ready),
        .grant(grant), .proto_err(proto_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_w_valid && mem_w_ready)
            wr_fires <= wr_fires + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one memory read beat, push its data to the scoreboard and check the routed copy.
    task automatic beat(input logic is_d, input logic [63:0] data, input logic last);
        logic [63:0] obs;
        mem_r_rdata = data;
        mem_r_rlast = last;
        mem_r_ready = 1'b1;
        exp_q.push_back(data);
        #1;
        obs = is_d ? d_r_rdata : i_r_rdata;
        chk("beat_data", obs, exp_q.pop_front());
        chk("beat_rlast", 64'(is_d ? d_r_rlast : i_r_rlast), 64'(last));
        chk("beat_dst_ready", 64'(is_d ? d_r_ready : i_r_ready), 64'd1);
        chk("beat_other_ready", 64'(is_d ? i_r_ready : d_r_ready), 64'd0);
        step();
        mem_r_ready = 1'b0;
        mem_r_rlast = 1'b0;
        mem_r_rdata = '0;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        n_tests = 0; n_fail = 0; wr_fires = 0;
        reset = 1'b0;
        i_r_valid = 0; i_r_raddr = '0; d_r_valid = 0; d_r_raddr = '0;
        d_w_valid = 0; d_w_waddr = '0; d_w_wdata = '0; d_w_wlast = 0; d_b_ready = 0;
        mem_r_rdata = '0; mem_r_rlast = 0; mem_r_ready = 0;
        mem_w_ready = 0; mem_b_valid = 0;
        step(); step();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_mem_r_valid", 64'(mem_r_valid), 64'd0);
        chk("rst_mem_w_valid", 64'(mem_w_valid), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        reset = 1'b1;
        step();

        // Simultaneous reads after reset: ICache first, one IDLE cycle, then DCache
        i_r_valid = 1; i_r_raddr = 64'h1000; d_r_valid = 1; d_r_raddr = 64'h2000;
        step();
        chk("rr1_grant_i", 64'(grant), 64'd1);
        chk("rr1_raddr_i", mem_r_raddr, 64'h1000);
        beat(1'b0, 64'hA1, 1'b0);
        beat(1'b0, 64'hA2, 1'b1);
        i_r_valid = 0;
        chk("rr1_idle_gap", 64'(grant), 64'd0);
        step();
        chk("rr1_grant_d", 64'(grant), 64'd2);
        chk("rr1_raddr_d", mem_r_raddr, 64'h2000);
        beat(1'b1, 64'hB1, 1'b0);
        beat(1'b1, 64'hB2, 1'b1);
        d_r_valid = 0;
        chk("rr1_end", 64'(grant), 64'd0);
        step();

        // ICache read only
        i_r_valid = 1; i_r_raddr = 64'h8000_0040;
        step();
        chk("ird_grant", 64'(grant), 64'd1);
        chk("ird_mem_valid", 64'(mem_r_valid), 64'd1);
        chk("ird_raddr", mem_r_raddr, 64'h8000_0040);
        beat(1'b0, 64'h11, 1'b0);
        beat(1'b0, 64'h22, 1'b1);
        i_r_valid = 0;
        chk("ird_end_grant", 64'(grant), 64'd0);
        chk("ird_proto_err", 64'(proto_err), 64'd0);
        step();

        // Both request again after an ICache grant: DCache wins this time
        i_r_valid = 1; i_r_raddr = 64'h3000; d_r_valid = 1; d_r_raddr = 64'h4000;
        step();
        chk("rr2_grant_d", 64'(grant), 64'd2);
        beat(1'b1, 64'hC1, 1'b0);
        beat(1'b1, 64'hC2, 1'b1);
        d_r_valid = 0;
        chk("rr2_idle_gap", 64'(grant), 64'd0);
        step();
        chk("rr2_grant_i", 64'(grant), 64'd1);
        beat(1'b0, 64'hD1, 1'b0);
        beat(1'b0, 64'hD2, 1'b1);
        i_r_valid = 0;
        step();

        // Write-back with backpressure, then refill with no IDLE gap; ICache waits
        d_w_valid = 1; d_w_waddr = 64'h100; d_w_wdata = 64'hE1; d_w_wlast = 0;
        d_r_valid = 1; d_r_raddr = 64'h5000;
        i_r_valid = 1; i_r_raddr = 64'h6000;
        wr_fires = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("wb_grant", 64'(grant), 64'd3);
            chk("wb_bp_ready", 64'(d_w_ready), 64'd0);
            chk("wb_bp_data", mem_w_wdata, 64'hE1);
            chk("wb_icache_blocked", 64'(i_r_ready | mem_r_valid), 64'd0);
            step();
        end
        mem_w_ready = 1;
        #1;
        chk("wb_ready_mirror", 64'(d_w_ready), 64'd1);
        chk("wb_addr", mem_w_waddr, 64'h100);
        chk("wb_beat1_last", 64'(mem_w_wlast), 64'd0);
        step();
        d_w_wdata = 64'hE2; d_w_wlast = 1;
        #1;
        chk("wb_beat2_data", mem_w_wdata, 64'hE2);
        chk("wb_beat2_last", 64'(mem_w_wlast), 64'd1);
        step();
        d_w_valid = 0; d_w_wlast = 0; mem_w_ready = 0;
        mem_b_valid = 1; d_b_ready = 1;
        #1;
        chk("wb_fires", 64'(wr_fires), 64'd2);
        chk("wb_b_valid", 64'(d_b_valid), 64'd1);
        chk("wb_b_ready", 64'(mem_b_ready), 64'd1);
        step();
        mem_b_valid = 0; d_b_ready = 0;
        chk("wb_to_dread", 64'(grant), 64'd2);
        chk("wb_refill_addr", mem_r_raddr, 64'h5000);
        beat(1'b1, 64'hF1, 1'b0);
        beat(1'b1, 64'hF2, 1'b1);
        d_r_valid = 0;
        chk("wb_refill_end", 64'(grant), 64'd0);
        step();
        chk("wb_icache_after", 64'(grant), 64'd1);
        beat(1'b0, 64'hF3, 1'b0);
        beat(1'b0, 64'hF4, 1'b1);
        i_r_valid = 0;
        chk("wb_proto_err", 64'(proto_err), 64'd0);
        step();

        // Early rlast on the first beat
        i_r_valid = 1; i_r_raddr = 64'h7000;
        step();
        beat(1'b0, 64'h33, 1'b1);
        i_r_valid = 0;
        chk("short_err", 64'(proto_err), 64'd1);
        step(); step();
        chk("short_sticky", 64'(proto_err), 64'd1);
        reset_pulse();
        chk("short_cleared", 64'(proto_err), 64'd0);

        // Three beats without rlast on the expected last beat
        d_r_valid = 1; d_r_raddr = 64'h7100;
        step();
        beat(1'b1, 64'h44, 1'b0);
        chk("long_beat1_ok", 64'(proto_err), 64'd0);
        beat(1'b1, 64'h55, 1'b0);
        chk("long_err", 64'(proto_err), 64'd1);
        beat(1'b1, 64'h66, 1'b1);
        d_r_valid = 0;
        chk("long_sticky", 64'(proto_err), 64'd1);
        chk("long_end", 64'(grant), 64'd0);
        step();

        // Asynchronous reset between beats of a DCache read
        d_r_valid = 1; d_r_raddr = 64'h7200;
        step();
        beat(1'b1, 64'h77, 1'b0);
        mem_r_ready = 1; mem_r_rdata = 64'h88; mem_r_rlast = 1;
        #1;
        reset = 1'b0;
        #1;
        chk("arst_grant", 64'(grant), 64'd0);
        chk("arst_mem_r_valid", 64'(mem_r_valid), 64'd0);
        chk("arst_d_r_ready", 64'(d_r_ready), 64'd0);
        chk("arst_d_r_rdata", d_r_rdata, 64'd0);
        chk("arst_d_r_rlast", 64'(d_r_rlast), 64'd0);
        chk("arst_mem_w", 64'(mem_w_valid | mem_b_ready | d_b_valid), 64'd0);
        chk("arst_proto_err", 64'(proto_err), 64'd0);
        mem_r_ready = 0; mem_r_rdata = '0; mem_r_rlast = 0; d_r_valid = 0;
        step();
        reset = 1'b1;
        step();
        i_r_valid = 1; i_r_raddr = 64'h9000;
        step();
        chk("post_rst_grant", 64'(grant), 64'd1);
        chk("post_rst_raddr", mem_r_raddr, 64'h9000);
        beat(1'b0, 64'h99, 1'b0);
        beat(1'b0, 64'hAA, 1'b1);
        i_r_valid = 0;
        chk("post_rst_end", 64'(grant), 64'd0);
        chk("post_rst_err", 64'(proto_err), 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
